// File: rtl/imem_pkg.sv
// imem_pkg: shared constants and helpers for the byte-addressed instruction memory
package imem_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int INSTR_BYTES = 4;

    function automatic int clog2_depth(input int d);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < d) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/imem_byte_ram.sv
// imem_byte_ram: byte-write array with a 4-byte big-endian combinational word read
module imem_byte_ram
    import imem_pkg::*;
#(
    parameter int DEPTH_BYTES = 128,
    localparam int A = clog2_depth(DEPTH_BYTES)
) (
    input  logic         clk,
    input  logic         we,
    input  logic [A-1:0] waddr,
    input  logic [7:0]   wdata,
    input  logic [A-1:0] raddr,
    output logic [31:0]  rdata
);
    logic [7:0] mem [DEPTH_BYTES];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    // lowest address lands in the most significant byte
    for (genvar i = 0; i < INSTR_BYTES; i++) begin : g_rd
        assign rdata[31-8*i -: 8] = mem[raddr + A'(i)];
    end
endmodule

// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: registered instruction fetch with stall/flush handshake, error flags and a byte load port
module instr_fetch_mem
    import imem_pkg::*;
#(
    parameter int DEPTH_BYTES = 128,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_req,
    input  logic [PC_W-1:0] fetch_pc,
    output logic            fetch_ready,
    input  logic            stall,
    input  logic            flush,
    output logic            instr_valid,
    output logic [31:0]     instr_code,
    output logic [PC_W-1:0] instr_pc,
    output logic            misalign_err,
    output logic            range_err,
    input  logic            load_we,
    input  logic [PC_W-1:0] load_addr,
    input  logic [7:0]      load_data
);
    localparam int A = clog2_depth(DEPTH_BYTES);

    logic [31:0] rd_word;
    logic        mis, rng, accept, hold;

    assign mis = fetch_pc[1:0] != 2'b00;
    assign rng = fetch_pc > PC_W'(DEPTH_BYTES - INSTR_BYTES);
    assign hold = instr_valid && stall;
    assign fetch_ready = !load_we && !hold;
    assign accept = fetch_req && fetch_ready && !flush;

    imem_byte_ram #(.DEPTH_BYTES(DEPTH_BYTES)) u_ram (
        .clk   (clk),
        .we    (load_we && load_addr < PC_W'(DEPTH_BYTES)),
        .waddr (load_addr[A-1:0]),
        .wdata (load_data),
        .raddr (fetch_pc[A-1:0]),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_valid  <= 1'b0;
            instr_code   <= '0;
            instr_pc     <= '0;
            misalign_err <= 1'b0;
            range_err    <= 1'b0;
        end else if (flush) begin
            instr_valid  <= 1'b0;
            misalign_err <= 1'b0;
            range_err    <= 1'b0;
        end else if (!hold) begin
            if (accept) begin
                instr_valid  <= 1'b1;
                instr_pc     <= fetch_pc;
                instr_code   <= (mis || rng) ? NOP_INSTR : rd_word;
                misalign_err <= mis;
                range_err    <= rng;
            end else begin
                instr_valid  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb_instr_fetch_mem: directed scoreboard bench for instr_fetch_mem
module tb_instr_fetch_mem;
    logic        clk = 0, reset = 0;
    logic        fetch_req = 0, stall = 0, flush = 0, load_we = 0;
    logic [31:0] fetch_pc = 0, load_addr = 0;
    logic [7:0]  load_data = 0;
    logic        fetch_ready, instr_valid, misalign_err, range_err;
    logic [31:0] instr_code, instr_pc;

    typedef struct {
        logic [31:0] code;
        logic [31:0] pc;
        logic        mis;
        logic        rng;
    } exp_t;

    exp_t q[$];
    logic [7:0] m [128];
    int vectors = 0, miscompares = 0;

    instr_fetch_mem #(.DEPTH_BYTES(128), .PC_W(32)) dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
        .fetch_ready(fetch_ready), .stall(stall), .flush(flush),
        .instr_valid(instr_valid), .instr_code(instr_code), .instr_pc(instr_pc),
        .misalign_err(misalign_err), .range_err(range_err),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] pc);
        exp_t e;
        logic [6:0] a;
        a = pc[6:0];
        e.pc = pc;
        e.mis = pc[1:0] != 2'b00;
        e.rng = pc > 32'd124;
        e.code = (e.mis || e.rng) ? 32'h0 :
                 {m[a], m[7'(a + 7'd1)], m[7'(a + 7'd2)], m[7'(a + 7'd3)]};
        return e;
    endfunction

    task automatic load(input logic [31:0] addr, input logic [7:0] d);
        @(negedge clk);
        load_we = 1; load_addr = addr; load_data = d;
        @(posedge clk); #1;
        load_we = 0;
        if (addr < 128) m[addr[6:0]] = d;
    endtask

    task automatic load_word(input logic [31:0] addr, input logic [31:0] w);
        for (int i = 0; i < 4; i++) load(addr + i, w[31-8*i -: 8]);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = q.pop_front();
        chk({tag, "_valid"}, instr_valid, 1);
        chk({tag, "_code"}, instr_code, e.code);
        chk({tag, "_pc"}, instr_pc, e.pc);
        chk({tag, "_mis"}, misalign_err, e.mis);
        chk({tag, "_rng"}, range_err, e.rng);
    endtask

    task automatic fetch(input string tag, input logic [31:0] pc);
        @(negedge clk);
        fetch_req = 1; fetch_pc = pc;
        #1 chk({tag, "_ready"}, fetch_ready, 1);
        q.push_back(model(pc));
        @(posedge clk); #1;
        fetch_req = 0;
        pop_check(tag);
    endtask

    initial begin
        #2;
        chk("rst_valid", instr_valid, 0);
        chk("rst_code", instr_code, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_mis", misalign_err, 0);
        chk("rst_rng", range_err, 0);
        chk("rst_ready", fetch_ready, 1);
        @(negedge clk) reset = 1;

        load_word(0, 32'h0001_1020);
        load_word(4, 32'h2002_0005);
        load_word(8, 32'h8c04_000c);
        load_word(16, 32'h1000_0003);
        load_word(32, 32'hac05_0010);
        load_word(72, 32'hdead_beef);
        load_word(124, 32'h0800_0001);

        fetch("be0", 0);
        chk("be0_lit", instr_code, 32'h0001_1020);
        fetch("be8", 8);
        chk("be8_lit", instr_code, 32'h8c04_000c);

        // back-to-back with a two-cycle stall after the first word
        fetch("bb0", 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            stall = 1; fetch_req = 1; fetch_pc = 4;
            #1 chk("stall_ready", fetch_ready, 0);
            @(posedge clk); #1;
            chk("stall_valid", instr_valid, 1);
            chk("stall_code", instr_code, 32'h0001_1020);
            chk("stall_pc", instr_pc, 0);
        end
        @(negedge clk) stall = 0;
        fetch("bb4", 4);
        fetch("bb8", 8);

        // idle cycle: valid drops, word and pc retained
        @(posedge clk); #1;
        chk("idle_valid", instr_valid, 0);
        chk("idle_code", instr_code, 32'h8c04_000c);
        chk("idle_pc", instr_pc, 8);

        fetch("fl16", 16);
        @(negedge clk);
        flush = 1; fetch_req = 1; fetch_pc = 32;
        @(posedge clk); #1;
        chk("flush_valid", instr_valid, 0);
        chk("flush_pc", instr_pc, 16);
        @(negedge clk) flush = 0; fetch_req = 0;
        fetch("fl32", 32);

        fetch("err2", 2);
        fetch("err128", 128);
        fetch("err126", 126);
        fetch("edge124", 124);

        // load beats fetch; out-of-range load is discarded
        @(negedge clk);
        load_we = 1; load_addr = 200; load_data = 8'hff; fetch_req = 1; fetch_pc = 0;
        #1 chk("ld_ready", fetch_ready, 0);
        @(posedge clk); #1;
        chk("ld_noaccept", instr_valid, 0);
        load_we = 0; fetch_req = 0;
        fetch("ld72", 72);
        chk("ld72_lit", instr_code, 32'hdead_beef);

        fetch("rs0", 4);
        #2 reset = 0;
        #1;
        chk("rs_valid", instr_valid, 0);
        chk("rs_code", instr_code, 0);
        chk("rs_pc", instr_pc, 0);
        @(negedge clk) reset = 1;
        fetch("rs_after", 0);
        chk("rs_after_lit", instr_code, 32'h0001_1020);

        chk("sb_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instr_fetch_mem.md
# instr_fetch_mem

Parametrised, byte-addressed, big-endian instruction memory for the IF stage of the MIPS pipeline, replacing the combinational ROM. Reads are registered (one-cycle latency) behind a req/ready handshake that honours IF/ID stall and branch/jump flush. A byte-wide load port programs the memory at run time. Misaligned and out-of-range fetches return a NOP with an error flag instead of garbage.

## Interface
- DEPTH_BYTES, 128: memory size in bytes; power of two, ≥ 4.
- PC_W, 32: width of fetch and load addresses.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; clears control/output registers only.
- fetch_req  in  1  IF requests the instruction at fetch_pc.
- fetch_pc  in  PC_W  byte address of the requested instruction.
- fetch_ready  out  1  request is accepted this cycle when high.
- stall  in  1  IF/ID hold; output registers must not change.
- flush  in  1  discard the in-flight or held instruction (taken beq / j).
- instr_valid  out  1  instr_code/instr_pc hold an accepted fetch.
- instr_code  out  32  big-endian instruction word.
- instr_pc  out  PC_W  address the word was fetched from.
- misalign_err  out  1  accepted fetch had fetch_pc[1:0] ≠ 0.
- range_err  out  1  accepted fetch had fetch_pc > DEPTH_BYTES-4.
- load_we  in  1  byte write enable.
- load_addr  in  PC_W  byte write address; writes outside range are ignored.
- load_data  in  8  byte to write.

## Operation
- Word read: instr_code = {M[a], M[a+1], M[a+2], M[a+3]}, where a = fetch_pc[log2(DEPTH_BYTES)-1:0]. MSB is at the lowest address.
- fetch_ready = !load_we && !(instr_valid && stall).
- Accept means fetch_req && fetch_ready && !flush.
- Output register update, evaluated in priority order:
  1. flush → instr_valid=0 and errors=0; any request that cycle is dropped.
  2. stall && instr_valid → hold all outputs.
  3. accept → instr_valid=1, instr_pc=fetch_pc, plus data and flags.
  4. otherwise → instr_valid=0; instr_code/instr_pc keep their last value.
- Error fetch: instr_code=32'h0000_0000 (MIPS NOP). Set misalign_err and/or range_err; both may be 1 together.
- Load: when load_we, M[load_addr] ← load_data at the edge.
  - A write in the same cycle as a read of the same byte is impossible, because fetch_ready=0 while load_we=1.
- Memory array is not reset. Contents persist across reset. Memory is uninitialised until loaded.
- No internal state machine beyond the valid/hold register. A full pipeline is not required.

## Timing
- Reset values: instr_valid=0, instr_code=0, instr_pc=0, misalign_err=0, range_err=0. fetch_ready follows its equation, so it is 1 when load_we=0.
- Latency: request accepted at edge N → data valid after edge N, usable in cycle N+1.
- Throughput: one fetch per cycle with no stall and no load.
- A stall lasting k cycles holds the word for k+1 visible cycles. No request is accepted during the stall while instr_valid=1.
- Flush has a one-cycle effect. A request in the cycle after a flush is accepted normally.
- Reset asserted mid-operation clears outputs immediately (asynchronous) and drops any accepted fetch. Loaded memory is unaffected.
- load_we and fetch_req together: the load wins, the fetch is not accepted, and IF must retry.

## Structure
- Shared package `imem_pkg` holds:
  - NOP_INSTR = 32'h0000_0000
  - INSTR_BYTES = 4
  - function clog2_depth
- Sub-module `imem_byte_ram`: DEPTH_BYTES × 8 array with one byte write port and a 4-byte big-endian combinational read at word base `a`.
- The top level holds the handshake and output registers, plus error detection.

## Test plan
- Big-endian read: load 00 01 10 20 at 0–3, then 8c 04 00 0c at 8–11; fetch pc 0 then 8 → instr_code 0x00011020 then 0x8c04000c, instr_pc 0 then 8, instr_valid=1 each following cycle.
- Back-to-back plus stall: fetch 0, 4, 8 on consecutive cycles; assert stall for 2 cycles after the first word → 0x00011020 held 3 cycles with fetch_ready=0; pc 4 is re-presented and returned afterwards.
- Flush: accept pc 16, assert flush the next cycle with fetch_req for pc 32 → instr_valid=0 for one cycle, pc 32 dropped; re-request pc 32 → its word appears one cycle later.
- Errors: fetch pc 2 → instr_code 0, misalign_err=1; fetch pc 128 (depth 128) → instr_code 0, range_err=1; fetch pc 126 → both flags set.
- Load priority: load_we=1 with fetch_req=1 → fetch_ready=0 and no accept; a load to addr 200 leaves the memory unchanged.
- Reset mid-run: assert reset between edges while instr_valid=1 → all outputs 0 immediately; after release, fetch pc 0 still returns 0x00011020.
